scale_dda_2d: RTL and testbench

- Parametrised two-axis fractional-step (DDA) decimation controller for the image-scaling datapath.
- Consumes a raster stream of source-pixel tokens. For each token it decides whether the pixel survives horizontal and vertical downscaling by ratios num/den, and emits destination coordinates for kept pixels.
- Tracks row and frame boundaries internally; no external row-end strobe.
- Has a start/done/abort control FSM, config validation and output backpressure.

---
 rtl/scale_pkg.sv | 15 +
 rtl/dda_phase.sv | 27 ++
 rtl/scale_dda_2d.sv | 167 ++++++++++++++++
 tb/tb_scale_dda_2d.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_pkg.sv
// Shared types, default widths and config validation for the two-axis DDA scaler.
package scale_pkg;

  localparam int ACC_W_DEF = 6;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // A ratio must be a true downscale (0 < num <= den) and the frame non-empty.
  function automatic logic cfg_valid(input logic [31:0] num_h, den_h, num_v, den_v, src_w, src_h);
    return (den_h != 0) && (den_v != 0) && (num_h != 0) && (num_v != 0) &&
           (num_h <= den_h) && (num_v <= den_v) && (src_w != 0) && (src_h != 0);
  endfunction

endpackage

// File: rtl/dda_phase.sv
// One axis of the fractional-step accumulator; keep reflects the pre-update phase.
module dda_phase #(
  parameter int ACC_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             clear,
  input  logic [ACC_W-1:0] num,
  input  logic [ACC_W-1:0] den,
  output logic             keep,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W:0] sum;

  assign sum  = {1'b0, acc} + {1'b0, num};
  assign keep = (sum >= {1'b0, den});

  // acc stays below den, so the wrapped result always fits in ACC_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        acc <= '0;
    else if (clear) acc <= '0;
    else if (step)  acc <= acc + num - (keep ? den : '0);
  end

endmodule

// File: rtl/scale_dda_2d.sv
// Two-axis DDA decimation controller: raster tokens in, keep flag and destination coordinates out.
module scale_dda_2d
  import scale_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [ACC_W-1:0] cfg_num_h,
  input  logic [ACC_W-1:0] cfg_den_h,
  input  logic [ACC_W-1:0] cfg_num_v,
  input  logic [ACC_W-1:0] cfg_den_v,
  input  logic [CNT_W-1:0] cfg_src_w,
  input  logic [CNT_W-1:0] cfg_src_h,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_keep,
  output logic [CNT_W-1:0] out_dst_col,
  output logic [CNT_W-1:0] out_dst_row,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] num_h_r, den_h_r, num_v_r, den_v_r;
  logic [CNT_W-1:0] src_w_r, src_h_r;
  logic [CNT_W-1:0] src_col, src_row, dst_col, dst_row;
  logic             row_keep_r, last_sent;
  logic             cfg_ok, start_go, accept, xfer;
  logic             col_first, col_last, row_last;
  logic             keep_h, keep_v, row_keep_now;
  logic [ACC_W-1:0] acc_h, acc_v;

  assign cfg_ok   = cfg_valid(32'(cfg_num_h), 32'(cfg_den_h), 32'(cfg_num_v),
                              32'(cfg_den_v), 32'(cfg_src_w), 32'(cfg_src_h));
  assign start_go = start & ~abort & (state == IDLE) & cfg_ok;
  assign in_ready = (state == RUN) & (~out_valid | out_ready) & ~last_sent;
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;

  assign col_first    = (src_col == '0);
  assign col_last     = (src_col == src_w_r - ONE);
  assign row_last     = (src_row == src_h_r - ONE);
  assign row_keep_now = col_first ? keep_v : row_keep_r;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  dda_phase #(.ACC_W(ACC_W)) u_phase_h (
    .clk  (clk),
    .rst  (rst),
    .step (accept),
    .clear(start_go | (accept & col_last)),
    .num  (num_h_r),
    .den  (den_h_r),
    .keep (keep_h),
    .acc  (acc_h)
  );

  dda_phase #(.ACC_W(ACC_W)) u_phase_v (
    .clk  (clk),
    .rst  (rst),
    .step (accept & col_first),
    .clear(start_go),
    .num  (num_v_r),
    .den  (den_v_r),
    .keep (keep_v),
    .acc  (acc_v)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_go) state_nxt = RUN;
      RUN:     if (xfer && out_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Config latch plus raster position; dst counters hold pre-increment values for the record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_h_r    <= '0;
      den_h_r    <= '0;
      num_v_r    <= '0;
      den_v_r    <= '0;
      src_w_r    <= '0;
      src_h_r    <= '0;
      src_col    <= '0;
      src_row    <= '0;
      dst_col    <= '0;
      dst_row    <= '0;
      row_keep_r <= 1'b0;
      last_sent  <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= start & ~abort & (state == IDLE) & ~cfg_ok;
      if (start_go) begin
        num_h_r    <= cfg_num_h;
        den_h_r    <= cfg_den_h;
        num_v_r    <= cfg_num_v;
        den_v_r    <= cfg_den_v;
        src_w_r    <= cfg_src_w;
        src_h_r    <= cfg_src_h;
        src_col    <= '0;
        src_row    <= '0;
        dst_col    <= '0;
        dst_row    <= '0;
        row_keep_r <= 1'b0;
        last_sent  <= 1'b0;
      end else if (accept) begin
        if (col_first) row_keep_r <= keep_v;
        if (col_last && row_last) last_sent <= 1'b1;
        if (col_last) begin
          src_col <= '0;
          dst_col <= '0;
          src_row <= src_row + ONE;
          if (row_keep_now) dst_row <= dst_row + ONE;
        end else begin
          src_col <= src_col + ONE;
          if (keep_h && row_keep_now) dst_col <= dst_col + ONE;
        end
      end
    end
  end

  // Output record register: loads on accept, drains on transfer, dropped by abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_keep    <= 1'b0;
      out_dst_col <= '0;
      out_dst_row <= '0;
      out_last    <= 1'b0;
    end else if (abort) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_keep    <= keep_h & row_keep_now;
      out_dst_col <= dst_col;
      out_dst_row <= dst_row;
      out_last    <= col_last & row_last;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  phase_in_range: assert property (@(posedge clk) disable iff (rst)
    (state == RUN) |-> ((acc_h < den_h_r) && (acc_v < den_v_r)));

endmodule

// File: tb/tb_scale_dda_2d.sv
// Self-checking bench for scale_dda_2d: vector table of frames, scoreboard against a floor-division model.
module tb_scale_dda_2d;

  localparam int ACC_W = 6;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [ACC_W-1:0] cfg_num_h = '0, cfg_den_h = '0, cfg_num_v = '0, cfg_den_v = '0;
  logic [CNT_W-1:0] cfg_src_w = '0, cfg_src_h = '0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             in_ready, out_valid, out_keep, out_last, busy, done, cfg_err;
  logic [CNT_W-1:0] out_dst_col, out_dst_row;

  scale_dda_2d #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_num_h(cfg_num_h), .cfg_den_h(cfg_den_h), .cfg_num_v(cfg_num_v), .cfg_den_v(cfg_den_v),
    .cfg_src_w(cfg_src_w), .cfg_src_h(cfg_src_h),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_keep(out_keep), .out_dst_col(out_dst_col), .out_dst_row(out_dst_row), .out_last(out_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int nh, dh, nv, dv, w, h;
    int stall_at;
    bit rand_bp;
    bit chg_cfg;
    int exp_kept;
    int exp_records;
  } vec_t;

  typedef struct {
    bit keep;
    int dcol;
    int drow;
    bit last;
  } rec_t;

  rec_t sbq[$];
  vec_t vecs[7];
  int   checks = 0;
  int   failures = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Column c survives when floor((c+1)*n/d) steps past floor(c*n/d); same for rows.
  function automatic rec_t model(input vec_t v, input int t);
    int   c = t % v.w;
    int   r = t / v.w;
    bit   kh = (((c + 1) * v.nh) / v.dh) > ((c * v.nh) / v.dh);
    bit   kv = (((r + 1) * v.nv) / v.dv) > ((r * v.nv) / v.dv);
    rec_t m;
    m.keep = kh && kv;
    m.dcol = (c * v.nh) / v.dh;
    m.drow = (r * v.nv) / v.dv;
    m.last = (c == v.w - 1) && (r == v.h - 1);
    return m;
  endfunction

  function automatic logic [17:0] rec_pack(input rec_t e);
    return {e.keep, e.last, e.keep ? 8'(e.dcol) : 8'd0, e.keep ? 8'(e.drow) : 8'd0};
  endfunction

  function automatic logic [17:0] dut_pack();
    return {out_keep, out_last, out_keep ? out_dst_col : 8'd0, out_keep ? out_dst_row : 8'd0};
  endfunction

  function automatic logic [22:0] all_outputs();
    return {in_ready, out_valid, out_keep, out_last, busy, done, cfg_err, out_dst_col, out_dst_row};
  endfunction

  task automatic drive_cfg(input int nh, dh, nv, dv, w, h);
    cfg_num_h = ACC_W'(nh);
    cfg_den_h = ACC_W'(dh);
    cfg_num_v = ACC_W'(nv);
    cfg_den_v = ACC_W'(dv);
    cfg_src_w = CNT_W'(w);
    cfg_src_h = CNT_W'(h);
  endtask

  task automatic start_frame(input vec_t v);
    @(posedge clk); #1;
    drive_cfg(v.nh, v.dh, v.nv, v.dv, v.w, v.h);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (v.chg_cfg) begin
      cfg_num_h = cfg_den_h;
      cfg_num_v = cfg_den_v;
      cfg_src_w = CNT_W'(v.w + 3);
    end
    @(negedge clk);
    check_output("busy_after_start", busy, 1);
  endtask

  // Runs one frame through the scoreboard, then checks the done pulse and totals.
  task automatic apply_stimulus(input vec_t v, input string tag);
    int          tok = 0;
    int          cyc = 0;
    int          kept = 0;
    int          nrec = 0;
    int          total = v.w * v.h;
    bit          last_seen = 1'b0;
    bit          done_seen = 1'b0;
    bit          snap_ok = 1'b0;
    bit          in_stall;
    logic [17:0] snap = '0;
    rec_t        e;
    start_frame(v);
    while (!last_seen && cyc < 4000) begin
      @(posedge clk); #1;
      in_stall  = (v.stall_at != 0) && (cyc >= v.stall_at) && (cyc < v.stall_at + 3);
      in_valid  = (tok < total) && (!v.rand_bp || $urandom_range(0, 3) != 0);
      out_ready = !in_stall && (!v.rand_bp || $urandom_range(0, 2) != 0);
      @(negedge clk);
      if (done) done_seen = 1'b1;
      if (in_stall && out_valid) begin
        check_output({tag, "_stall_in_ready"}, in_ready, 0);
        if (snap_ok) check_output({tag, "_stall_hold"}, dut_pack(), snap);
        snap    = dut_pack();
        snap_ok = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check_output({tag, "_unexpected_record"}, 1, 0);
        end else begin
          e = sbq.pop_front();
          check_output({tag, "_record"}, dut_pack(), rec_pack(e));
          nrec++;
          if (out_keep) kept++;
        end
        if (out_last) last_seen = 1'b1;
      end
      if (in_valid && in_ready) begin
        sbq.push_back(model(v, tok));
        tok++;
      end
      cyc++;
    end
    if (!last_seen) check_output({tag, "_frame_timeout"}, cyc, 0);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_output({tag, "_done_pulse"}, done, 1);
    check_output({tag, "_done_early"}, done_seen, 0);
    @(negedge clk);
    check_output({tag, "_done_cleared"}, {done, busy}, 0);
    check_output({tag, "_kept_count"}, kept, v.exp_kept);
    check_output({tag, "_record_count"}, nrec, v.exp_records);
    check_output({tag, "_queue_empty"}, sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic bad_start(input int nh, dh, nv, dv, w, h, input string name);
    @(posedge clk); #1;
    drive_cfg(nh, dh, nv, dv, w, h);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_output({name, "_cfg_err"}, {cfg_err, busy, in_ready}, 3'b100);
    @(negedge clk);
    check_output({name, "_cfg_err_pulse"}, {cfg_err, busy}, 0);
  endtask

  initial begin
    int   tok;
    int   guard;
    bit   done_seen;
    rec_t e;
    vec_t va;

    //           nh  dh  nv  dv  w  h stall rbp chg kept recs
    vecs[0] = '{ 2,  3,  1,  1, 6, 1,  0,   0,  0,  4,   6};
    vecs[1] = '{ 1,  1,  1,  2, 2, 4,  0,   0,  0,  4,   8};
    vecs[2] = '{ 3,  4,  2,  3, 5, 3,  0,   0,  1,  6,  15};
    vecs[3] = '{ 1,  1,  1,  1, 1, 1,  0,   0,  0,  1,   1};
    vecs[4] = '{ 5,  7,  3,  5, 7, 2,  0,   1,  0,  5,  14};
    vecs[5] = '{63, 63, 63, 63, 3, 2,  0,   1,  0,  6,   6};
    vecs[6] = '{ 2,  3,  1,  1, 6, 1,  3,   0,  0,  4,   6};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_outputs", all_outputs(), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    bad_start(4, 3, 1, 1, 6, 1, "num_gt_den");
    bad_start(1, 1, 1, 0, 6, 1, "den_v_zero");
    bad_start(1, 1, 1, 1, 0, 1, "src_w_zero");

    // abort wins over a simultaneous start
    @(posedge clk); #1;
    drive_cfg(1, 1, 1, 1, 2, 2);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_output("abort_beats_start", {busy, cfg_err}, 0);

    // abort after three tokens, then the same frame must replay from a clean phase
    va = vecs[0];
    start_frame(va);
    tok   = 0;
    guard = 0;
    while (tok < 3 && guard < 50) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      if (out_valid && out_ready && sbq.size() != 0) begin
        e = sbq.pop_front();
        check_output("abort_pre_record", dut_pack(), rec_pack(e));
      end
      if (in_valid && in_ready) begin
        sbq.push_back(model(va, tok));
        tok++;
      end
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    abort    = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check_output("abort_to_idle", {busy, out_valid, in_ready}, 0);
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    check_output("abort_no_done", done_seen, 0);
    sbq.delete();
    apply_stimulus(va, "after_abort");

    // asynchronous reset in the middle of a cycle
    va = vecs[5];
    start_frame(va);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_output("pre_reset_valid", {out_valid, busy}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_reset_outputs", all_outputs(), 0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    sbq.delete();
    apply_stimulus(vecs[1], "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
